// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Each grant lasts up to MAX_BURST words; the FIFO full flag stalls the granted requester.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      burst_done
);

    localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [3:0]      count_q, count_d;
    logic [ID_W-1:0] winner, idx;
    logic            any_valid;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        winner    = rr_ptr_q;
        idx       = rr_ptr_q;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = rr_ptr_q + ID_W'(i);
            if (req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        count_d      = count_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        burst_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    count_d = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                req_ready[grant_q] = !fifo_full && !rst;
                fifo_wr_en         = req_valid[grant_q] && !fifo_full && !rst;
                if (fifo_wr_en) begin
                    fifo_wr_data = req_data[grant_q*DATA_W +: DATA_W];
                    count_d      = count_q + 4'd1;
                end
                // A full FIFO with valid still asserted stalls rather than ends the burst.
                if ((fifo_wr_en && count_q == LastBeat) || !req_valid[grant_q]) begin
                    burst_done = !rst;
                    state_d    = StIdle;
                    rr_ptr_d   = grant_q + ID_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == StBurst);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the CDC FIFO between NUM_REQ requesters in the write clock domain. Grants one requester at a time for a burst of up to MAX_BURST words. Back-pressures all requesters from the FIFO full flag. Sits directly in front of the FIFO write side, inside the same top-level wrapper.

Parameters:
NUM_REQ, 4, number of requesters (power of 2, 2..8)
DATA_W, 8, FIFO word width
MAX_BURST, 4, maximum words transferred per grant (1..15)
ID_W, 2, width of grant_id; equals log2(NUM_REQ)

Ports:
clk  in  1  write-domain clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester word available
req_data  in  NUM_REQ*DATA_W  packed words; requester i at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester word accepted this cycle when valid&ready
fifo_full  in  1  FIFO write-side full flag
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  DATA_W  FIFO write data
grant_id  out  ID_W  index of the currently or last granted requester
busy  out  1  high while in BURST
burst_done  out  1  one-cycle pulse on the cycle a burst ends

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; rr_ptr=0; grant_id=0; beat count=0; busy=0; burst_done=0; req_ready=0; fifo_wr_en=0; fifo_wr_data=0.
- State IDLE:
  - req_ready all 0; fifo_wr_en 0.
  - If any req_valid is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On the next edge: grant_id<=winner, count<=0, state<=BURST.
  - With no valid, stay in IDLE.
- State BURST, with g=grant_id:
  - req_ready[g] = !fifo_full (combinational); all other req_ready are 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_wr_data = req_data slice g, driven combinationally. It is 0 whenever fifo_wr_en is 0.
  - On each transfer, count increments.
- Burst termination, on the edge concerned:
  - (a) A transfer with count==MAX_BURST-1.
  - (b) req_valid[g]=0 in BURST (no transfer that cycle).
  - On termination: state<=IDLE, rr_ptr<=(g+1) mod NUM_REQ, and burst_done is high for exactly that one BURST cycle (combinational from state and conditions).
- fifo_full with req_valid[g]=1: stall. No transfer, count held, the burst does not end, and other requesters wait.
- Latency: first word is written 1 cycle after req_valid rises in IDLE. One IDLE bubble cycle separates consecutive bursts.
- Simultaneous requests: rotating priority guarantees each continuously-valid requester a grant within NUM_REQ bursts.
- A requester dropping valid mid-burst loses the grant and must re-arbitrate. Its words already written stand.
- The arbiter ignores changes on non-granted req_valid lines during BURST.
- Reset asserted mid-burst: the next edge returns to reset values. No further fifo_wr_en while rst is high (fifo_wr_en gated by !rst).
- Throughput: with fifo_full=0 and a continuously valid granted requester, MAX_BURST words are written in MAX_BURST consecutive cycles.

Test Plan:
- Single requester: req_valid=4'b0100, data 0xA0..0xA7, fifo_full=0.
  -> wr_en the cycle after valid. Burst 1 writes 0xA0..0xA3 in 4 cycles, grant_id=2, burst_done on the 4th. One bubble. Burst 2 writes 0xA4..0xA7.
- All four requesters valid continuously, rr_ptr=0 after reset.
  -> grant order 0,1,2,3,0. Each burst is exactly 4 writes, and busy drops for 1 cycle between bursts.
- Back-pressure: fifo_full=1 for 3 cycles after the 2nd word of a burst.
  -> wr_en=0 and req_ready[g]=0 during those cycles. Words 3 and 4 written after full clears. Total still 4, no data loss or duplication.
- Early end: granted requester 1 drops valid after 2 words.
  -> burst_done in the drop cycle, rr_ptr=2. A pending requester 3 is granted next, ahead of requester 0.
- Reset mid-burst: rst=1 in the cycle after the 2nd write.
  -> from the next edge: busy=0, grant_id=0, wr_en=0. After release with all valid, requester 0 is granted first.
- MAX_BURST=1 build with requesters 0 and 2 valid.
  -> alternating single writes 0,2,0,2, with a 1-cycle gap between each.
